// File: rtl/nn_mem_pkg.sv
// Shared sizing defaults, width helper and burst FSM states for the weight memory.
// No logic; imported by the bank and the streamer.
package nn_mem_pkg;

  localparam int NUM_CH_DEF = 28;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 785;

  // Index width for n items; never below 1 so a single-item port still has a bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bram_sp.sv
// Single-port weight bank, write-first.
// Latency: 1 cycle registered read. Backpressure: none; dout holds while en is low.
module bram_sp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 785,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
        dout      <= din;
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/weight_bank_streamer.sv
// NUM_CH weight banks with per-channel load and a burst read of all lanes per address.
// Latency: START at edge T0, first read at T1, DO_VALID from T2. Backpressure: 2-entry skid, reads issued only with room.
module weight_bank_streamer
  import nn_mem_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = idx_w(DEPTH),
  localparam int CH_W   = idx_w(NUM_CH)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WE,
  input  logic [CH_W-1:0]          WCH,
  input  logic [ADDR_W-1:0]        WADDR,
  input  logic [DATA_W-1:0]        DI,
  input  logic                     START,
  input  logic [ADDR_W-1:0]        BASE,
  input  logic [ADDR_W:0]          LEN,
  output logic [NUM_CH*DATA_W-1:0] DO,
  output logic                     DO_VALID,
  input  logic                     DO_READY,
  output logic [ADDR_W-1:0]        DO_IDX,
  output logic                     DO_LAST,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     CMD_ERR
);

  localparam logic [CH_W:0]     NUM_CH_C = (CH_W+1)'(NUM_CH);
  localparam logic [ADDR_W+1:0] DEPTH_C  = (ADDR_W+2)'(DEPTH);

  typedef struct packed {
    logic [NUM_CH*DATA_W-1:0] dat;
    logic [ADDR_W-1:0]        idx;
    logic                     last;
  } beat_t;

  state_t                   state;
  logic [ADDR_W-1:0]        rd_addr;
  logic [ADDR_W-1:0]        rd_end;
  logic                     rd_vld;
  logic [ADDR_W-1:0]        rd_idx;
  logic                     rd_last;
  logic [NUM_CH*DATA_W-1:0] bank_dat;
  beat_t                    slot0;
  beat_t                    slot1;
  logic                     v0;
  logic                     v1;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;

  logic                     idle;
  logic                     pop;
  logic [1:0]               occ;
  logic                     issue;
  logic [ADDR_W+1:0]        end_sum;
  logic                     start_ok;
  logic                     wr_ok;
  logic                     wr_en;
  logic [ADDR_W-1:0]        bank_addr;
  beat_t                    push_beat;

  always_comb begin
    idle     = (state == IDLE);
    pop      = v0 && DO_READY;
    // Skid slots plus the word already in the bank register must leave room for one more.
    occ      = {1'b0, v0} + {1'b0, v1} + {1'b0, rd_vld};
    issue    = (state == RUN) && ({1'b0, occ} < (pop ? 3'd3 : 3'd2));
    end_sum  = {2'b00, BASE} + {1'b0, LEN};
    start_ok = (LEN != '0) && (end_sum <= DEPTH_C);
    wr_ok    = ({1'b0, WCH} < NUM_CH_C) && ({2'b00, WADDR} < DEPTH_C);
    wr_en    = idle && WE && wr_ok;
    bank_addr = idle ? WADDR : rd_addr;
    push_beat = '{dat: bank_dat, idx: rd_idx, last: rd_last};
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_bank
    logic bank_we;
    assign bank_we = wr_en && (WCH == CH_W'(k));
    bram_sp #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_bank (
      .clk (CLK),
      .en  (issue || bank_we),
      .we  (bank_we),
      .addr(bank_addr),
      .din (DI),
      .dout(bank_dat[k*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      rd_addr <= '0;
      rd_end  <= '0;
      rd_vld  <= 1'b0;
      rd_idx  <= '0;
      rd_last <= 1'b0;
      slot0   <= '0;
      slot1   <= '0;
      v0      <= 1'b0;
      v1      <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rd_vld <= issue;

      unique case (state)
        IDLE: begin
          if ((WE && !wr_ok) || (START && !start_ok)) err_q <= 1'b1;
          if (START && start_ok) begin
            state   <= RUN;
            busy_q  <= 1'b1;
            rd_addr <= BASE;
            // Modular arithmetic keeps this right even when LEN equals 2**ADDR_W.
            rd_end  <= BASE + LEN[ADDR_W-1:0] - ADDR_W'(1);
          end
        end
        RUN: begin
          if (WE) err_q <= 1'b1;
          if (issue) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            rd_idx  <= rd_addr;
            rd_last <= (rd_addr == rd_end);
            if (rd_addr == rd_end) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (WE) err_q <= 1'b1;
          if (pop && slot0.last) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        if (v1) begin
          slot0 <= slot1;
          if (rd_vld) slot1 <= push_beat;
          else        v1    <= 1'b0;
        end else if (rd_vld) begin
          slot0 <= push_beat;
        end else begin
          v0 <= 1'b0;
        end
      end else if (rd_vld) begin
        if (!v0) begin
          slot0 <= push_beat;
          v0    <= 1'b1;
        end else begin
          slot1 <= push_beat;
          v1    <= 1'b1;
        end
      end
    end
  end

  assign DO       = slot0.dat;
  assign DO_IDX   = slot0.idx;
  assign DO_LAST  = slot0.last;
  assign DO_VALID = v0;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign CMD_ERR  = err_q;

endmodule
